// File: rtl/laser_pkg.sv
// Shared types and constants for the player laser controller.
package laser_pkg;

    // Controller states: READY accepts a shot, COOL waits out the cooldown,
    // HALT holds everything cleared while the player is dead.
    typedef enum logic [1:0] {
        READY = 2'd0,
        COOL  = 2'd1,
        HALT  = 2'd2
    } ctrl_state_e;

    // Width of a screen coordinate.
    localparam int unsigned coord_w = 10;

    // Width of the cooldown counter.
    localparam int unsigned cool_w = 4;

    // Screen geometry.
    localparam int unsigned screen_w = 640;
    localparam int unsigned screen_h = 480;

    // Laser colour as 4:4:4 RGB, used by the display logic.
    localparam logic [11:0] laser_color = 12'hF00;

endpackage

// File: rtl/laser_slot.sv
// One laser slot: holds valid/x/y and applies clear > hit > spawn load > move.
module laser_slot
    import laser_pkg::*;
#(
    parameter int unsigned step_p       = 8,
    parameter int unsigned spawn_y_p    = 440,
    parameter int unsigned top_border_p = 10
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,   // player dead: drop the laser
    input  logic               hit_i,     // collision clear, ignored when idle
    input  logic               load_i,    // spawn into this slot
    input  logic               move_i,    // unpaused frame tick
    input  logic [coord_w-1:0] x_i,       // gun x sampled in the spawn cycle
    output logic               valid_o,
    output logic [coord_w-1:0] x_o,
    output logic [coord_w-1:0] y_o
);

    localparam logic [coord_w-1:0] StepY    = coord_w'(step_p);
    localparam logic [coord_w-1:0] SpawnY   = coord_w'(spawn_y_p);
    // A laser only moves if the result stays at or below the top border.
    localparam logic [coord_w-1:0] MinMoveY = coord_w'(top_border_p + step_p);

    logic               valid_q, valid_d;
    logic [coord_w-1:0] x_q, x_d;
    logic [coord_w-1:0] y_q, y_d;

    // Next-state: clear/hit retire, spawn load on a free slot, else move or retire at top.
    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        if (clear_i || (hit_i && valid_q)) begin
            valid_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (load_i && !valid_q) begin
            valid_d = 1'b1;
            x_d     = x_i;
            y_d     = SpawnY;
        end else if (move_i && valid_q) begin
            if (y_q >= MinMoveY) begin
                y_d = y_q - StepY;
            end else begin
                valid_d = 1'b0;
                x_d     = '0;
                y_d     = '0;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/laser_ctrl.sv
// Player laser controller: shot qualification, cooldown, slot allocation and
// per-frame laser motion.
// Build option: define LASER_AUTOFIRE_EN to fire on the shoot level instead of
// its rising edge.
module laser_ctrl
    import laser_pkg::*;
#(
    parameter int unsigned num_slots_p  = 2,
    parameter int unsigned step_p       = 8,
    parameter int unsigned cooldown_p   = 15,
    parameter int unsigned spawn_y_p    = 440,
    parameter int unsigned top_border_p = 10
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           frame_i,
    input  logic                           shoot_i,
    input  logic                           alive_i,
    input  logic                           pause_i,
    input  logic [coord_w-1:0]             gun_pos_i,
    input  logic [num_slots_p-1:0]         hit_slot_i,
    output logic [num_slots_p-1:0]         laser_valid_o,
    output logic [coord_w*num_slots_p-1:0] laser_x_o,
    output logic [coord_w*num_slots_p-1:0] laser_y_o,
    output logic                           shot_laser_o,
    output logic                           ready_o
);

    localparam logic [cool_w-1:0] CoolInit = cool_w'(cooldown_p);

    ctrl_state_e           state_q, state_d;
    logic [cool_w-1:0]     cool_q, cool_d;
    logic                  shot_q;
    logic                  ready_q;
    logic                  fire_req;
    logic                  move;
    logic                  spawn;
    logic                  any_free;
    logic [num_slots_p-1:0] spawn_sel;

    // Frame ticks only count while the level is running.
    assign move = frame_i & ~pause_i;

`ifdef LASER_AUTOFIRE_EN
    // Holding the button re-fires whenever the controller is READY again.
    assign fire_req = shoot_i;
`else
    logic shoot_q;

    // Previous shoot level for rising-edge qualification.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shoot_q <= 1'b0;
        end else begin
            shoot_q <= shoot_i;
        end
    end

    assign fire_req = shoot_i & ~shoot_q;
`endif

    // Lowest-index free slot; any_free is low when every slot is in flight.
    always_comb begin
        spawn_sel = '0;
        any_free  = 1'b0;
        for (int unsigned k = 0; k < num_slots_p; k++) begin
            if (!any_free && !laser_valid_o[k]) begin
                spawn_sel[k] = 1'b1;
                any_free     = 1'b1;
            end
        end
    end

    // Presses that do not meet every condition here are dropped, not queued.
    assign spawn = (state_q == READY) & fire_req & alive_i & ~pause_i & any_free;

    // Controller next state and cooldown counter.
    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;

        if (!alive_i) begin
            cool_d = '0;
        end else if (spawn) begin
            cool_d = CoolInit;
        end else if (move && (cool_q != '0)) begin
            cool_d = cool_q - cool_w'(1);
        end

        if (!alive_i) begin
            state_d = HALT;
        end else begin
            case (state_q)
                READY:   if (spawn) state_d = COOL;
                COOL:    if (cool_q == '0) state_d = READY;
                HALT:    state_d = READY;
                default: state_d = READY;
            endcase
        end
    end

    // Controller state, cooldown and registered status outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= READY;
            cool_q  <= '0;
            shot_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            shot_q  <= spawn;
            ready_q <= (state_d == READY);
        end
    end

    assign shot_laser_o = shot_q;
    assign ready_o      = ready_q;

    for (genvar k = 0; k < num_slots_p; k++) begin : g_slot
        laser_slot #(
            .step_p       (step_p),
            .spawn_y_p    (spawn_y_p),
            .top_border_p (top_border_p)
        ) u_slot (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .clear_i (~alive_i),
            .hit_i   (hit_slot_i[k]),
            .load_i  (spawn & spawn_sel[k]),
            .move_i  (move),
            .x_i     (gun_pos_i),
            .valid_o (laser_valid_o[k]),
            .x_o     (laser_x_o[coord_w*k +: coord_w]),
            .y_o     (laser_y_o[coord_w*k +: coord_w])
        );
    end

endmodule

// File: tb/tb_laser_ctrl.sv
// Directed bench for laser_ctrl (default build, edge-qualified shooting).
module tb_laser_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame;
    logic        shoot;
    logic        alive;
    logic        pause;
    logic [9:0]  gun_pos;
    logic [1:0]  hit_slot;
    logic [1:0]  laser_valid;
    logic [19:0] laser_x;
    logic [19:0] laser_y;
    logic        shot;
    logic        ready;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    laser_ctrl u_dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .frame_i       (frame),
        .shoot_i       (shoot),
        .alive_i       (alive),
        .pause_i       (pause),
        .gun_pos_i     (gun_pos),
        .hit_slot_i    (hit_slot),
        .laser_valid_o (laser_valid),
        .laser_x_o     (laser_x),
        .laser_y_o     (laser_y),
        .shot_laser_o  (shot),
        .ready_o       (ready)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame strobe followed by an idle cycle.
    task automatic do_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
    endtask

    // One-cycle shoot press; returns right after the edge that sees it.
    task automatic press(input logic [9:0] g);
        gun_pos = g;
        shoot   = 1'b1;
        tick();
        shoot   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame = 1'b0; shoot = 1'b0; alive = 1'b1; pause = 1'b0;
        gun_pos = '0; hit_slot = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        nvec++; if (laser_valid !== 2'b00) begin nerr++;
            $display("FAIL reset_valid: got %b want 00", laser_valid); end
        nvec++; if (laser_x !== 20'd0) begin nerr++;
            $display("FAIL reset_x: got %h want 0", laser_x); end
        nvec++; if (laser_y !== 20'd0) begin nerr++;
            $display("FAIL reset_y: got %h want 0", laser_y); end
        nvec++; if (shot !== 1'b0) begin nerr++;
            $display("FAIL reset_shot: got %b want 0", shot); end
        nvec++; if (ready !== 1'b1) begin nerr++;
            $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    // Spawn coincident with a frame strobe; that frame counts as frame 1.
    task automatic test_spawn_and_fly();
        gun_pos = 10'd200; shoot = 1'b1; frame = 1'b1;
        tick();
        shoot = 1'b0; frame = 1'b0;
        nvec++; if (laser_valid !== 2'b01) begin nerr++;
            $display("FAIL spawn_valid: got %b want 01", laser_valid); end
        nvec++; if (laser_x[9:0] !== 10'd200) begin nerr++;
            $display("FAIL spawn_x: got %0d want 200", laser_x[9:0]); end
        nvec++; if (laser_y[9:0] !== 10'd440) begin nerr++;
            $display("FAIL spawn_y: got %0d want 440", laser_y[9:0]); end
        nvec++; if (shot !== 1'b1) begin nerr++;
            $display("FAIL spawn_shot: got %b want 1", shot); end
        nvec++; if (ready !== 1'b0) begin nerr++;
            $display("FAIL spawn_ready: got %b want 0", ready); end
        tick();
        nvec++; if (shot !== 1'b0) begin nerr++;
            $display("FAIL shot_pulse_width: got %b want 0", shot); end
        for (int f = 2; f <= 55; f++) begin
            int exp_y;
            do_frame();
            exp_y = 440 - 8 * (f - 1);
            if (f <= 54) begin
                nvec++; if (laser_valid[0] !== 1'b1 || laser_y[9:0] !== 10'(exp_y)) begin
                    nerr++;
                    $display("FAIL fly_frame%0d: valid %b y %0d want valid 1 y %0d",
                             f, laser_valid[0], laser_y[9:0], exp_y);
                end
            end else begin
                nvec++; if (laser_valid[0] !== 1'b0) begin nerr++;
                    $display("FAIL retire_frame55: valid %b want 0", laser_valid[0]); end
            end
        end
        nvec++; if (ready !== 1'b1) begin nerr++;
            $display("FAIL ready_after_cool: got %b want 1", ready); end
    endtask

    task automatic test_hold_shoot();
        int spawns = 0;
        gun_pos = 10'd120;
        shoot   = 1'b1;
        for (int f = 0; f < 100; f++) begin
            frame = 1'b1;
            tick();
            if (shot === 1'b1) spawns++;
            frame = 1'b0;
            tick();
            if (shot === 1'b1) spawns++;
        end
        shoot = 1'b0;
        nvec++; if (spawns != 1) begin nerr++;
            $display("FAIL hold_spawns: got %0d want 1", spawns); end
        for (int f = 0; f < 60; f++) do_frame();
        nvec++; if (laser_valid !== 2'b00) begin nerr++;
            $display("FAIL hold_cleanup: got %b want 00", laser_valid); end
    endtask

    task automatic test_slots_full();
        press(10'd40);
        for (int f = 0; f < 16; f++) do_frame();
        press(10'd80);
        nvec++; if (laser_valid !== 2'b11) begin nerr++;
            $display("FAIL full_two_valid: got %b want 11", laser_valid); end
        for (int f = 0; f < 16; f++) do_frame();
        press(10'd90);
        nvec++; if (shot !== 1'b0 || laser_valid !== 2'b11) begin nerr++;
            $display("FAIL full_drop: shot %b valid %b want shot 0 valid 11", shot, laser_valid); end
        tick();
        hit_slot = 2'b01;
        tick();
        hit_slot = 2'b00;
        nvec++; if (laser_valid !== 2'b10) begin nerr++;
            $display("FAIL hit_slot0: got %b want 10", laser_valid); end
        press(10'd300);
        nvec++; if (shot !== 1'b1 || laser_valid !== 2'b11) begin nerr++;
            $display("FAIL respawn: shot %b valid %b want shot 1 valid 11", shot, laser_valid); end
        nvec++; if (laser_x[9:0] !== 10'd300 || laser_y[9:0] !== 10'd440) begin nerr++;
            $display("FAIL respawn_xy: x %0d y %0d want 300 440", laser_x[9:0], laser_y[9:0]); end
        nvec++; if (laser_y[19:10] !== 10'd312) begin nerr++;
            $display("FAIL slot1_y: got %0d want 312", laser_y[19:10]); end
        for (int f = 0; f < 60; f++) do_frame();
        nvec++; if (laser_valid !== 2'b00) begin nerr++;
            $display("FAIL full_cleanup: got %b want 00", laser_valid); end
    endtask

    task automatic test_pause();
        int shots = 0;
        press(10'd100);
        nvec++; if (shot !== 1'b1 || laser_valid !== 2'b01) begin nerr++;
            $display("FAIL pause_spawn: shot %b valid %b want 1 01", shot, laser_valid); end
        for (int f = 0; f < 3; f++) do_frame();
        nvec++; if (laser_y[9:0] !== 10'd416) begin nerr++;
            $display("FAIL pre_pause_y: got %0d want 416", laser_y[9:0]); end
        pause = 1'b1;
        for (int f = 0; f < 20; f++) begin
            do_frame();
            if (f == 5) begin
                press(10'd500);
                if (shot === 1'b1) shots++;
            end
        end
        nvec++; if (shots != 0) begin nerr++;
            $display("FAIL pause_press: got %0d shots want 0", shots); end
        nvec++; if (laser_y[9:0] !== 10'd416 || laser_valid !== 2'b01) begin nerr++;
            $display("FAIL pause_frozen: y %0d valid %b want 416 01", laser_y[9:0], laser_valid); end
        nvec++; if (ready !== 1'b0) begin nerr++;
            $display("FAIL pause_cool_frozen: ready %b want 0", ready); end
        pause = 1'b0;
        do_frame();
        nvec++; if (laser_y[9:0] !== 10'd408) begin nerr++;
            $display("FAIL resume_y: got %0d want 408", laser_y[9:0]); end
        for (int f = 0; f < 10; f++) do_frame();
        nvec++; if (ready !== 1'b0) begin nerr++;
            $display("FAIL cool_one_left: ready %b want 0", ready); end
        do_frame();
        nvec++; if (ready !== 1'b1) begin nerr++;
            $display("FAIL cool_done: ready %b want 1", ready); end
    endtask

    task automatic test_alive();
        press(10'd50);
        nvec++; if (laser_valid !== 2'b11) begin nerr++;
            $display("FAIL alive_two_valid: got %b want 11", laser_valid); end
        tick();
        alive = 1'b0;
        tick();
        nvec++; if (laser_valid !== 2'b00 || ready !== 1'b0) begin nerr++;
            $display("FAIL dead_clear: valid %b ready %b want 00 0", laser_valid, ready); end
        press(10'd60);
        nvec++; if (shot !== 1'b0 || laser_valid !== 2'b00) begin nerr++;
            $display("FAIL dead_press: shot %b valid %b want 0 00", shot, laser_valid); end
        tick();
        alive = 1'b1;
        tick();
        nvec++; if (ready !== 1'b1) begin nerr++;
            $display("FAIL revive_ready: got %b want 1", ready); end
        press(10'd77);
        nvec++; if (shot !== 1'b1 || laser_valid !== 2'b01 || laser_x[9:0] !== 10'd77) begin
            nerr++;
            $display("FAIL revive_spawn: shot %b valid %b x %0d want 1 01 77",
                     shot, laser_valid, laser_x[9:0]);
        end
    endtask

    // Reset lands between clock edges and must clear the slot at once.
    task automatic test_reset_midflight();
        tick();
        #2;
        reset = 1'b1;
        #1;
        nvec++; if (laser_valid !== 2'b00 || ready !== 1'b1) begin nerr++;
            $display("FAIL async_reset: valid %b ready %b want 00 1", laser_valid, ready); end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn_and_fly();
        test_hold_shoot();
        test_slots_full();
        test_pause();
        test_alive();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
